// File: rtl/monocicle_pkg.sv
// Shared types for the instruction-memory loader.
// State encoding, stream header size and error codes.
package monocicle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_LEN = 2;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_LEN   = 2'b01;
  localparam logic [1:0] ERR_CKSUM = 2'b10;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_full flags the load that completes a word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      // first byte ends up in bits 7:0 after four shifts
      word <= {data, word[31:8]};
      idx  <= idx + 2'd1;
    end
  end

  assign word_full = load & (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the instruction-memory write port.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing mod-256 checksum byte.
import monocicle_pkg::*;

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t state, nxt;

  logic              take;
  logic              go;
  logic              full;
  logic              ld;
  logic              ovf;
  logic [7:0]        len_lo;
  logic [15:0]       n;
  logic [15:0]       cnt;
  logic [15:0]       cnt_nxt;
  logic [16:0]       len_in;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        ec;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
  logic [7:0] sum;
  logic       cks_ok;
  assign cks_ok = (byte_data == sum);
`else
  localparam state_t S_FIN = S_DONE;
`endif

  assign byte_ready = (state == S_LEN_LO) | (state == S_LEN_HI)
                    | (state == S_DATA) | (state == S_CHK);
  assign take    = byte_valid & byte_ready;
  assign go      = start & ((state == S_IDLE) | (state == S_DONE)
                 | (state == S_ERR));
  assign ld      = take & (state == S_DATA);
  assign len_in  = {1'b0, byte_data, len_lo};
  assign ovf     = len_in > CAP;
  assign cnt_nxt = cnt + 16'd1;

  byte_packer u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (go),
    .load      (ld),
    .data      (byte_data),
    .word      (imem_wdata),
    .word_full (full)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) nxt = S_LEN_LO;
      S_LEN_LO:
        if (take) nxt = S_LEN_HI;
      S_LEN_HI:
        if (take) begin
          if (ovf)                 nxt = S_ERR;
          else if (len_in == '0)   nxt = S_FIN;
          else                     nxt = S_DATA;
        end
      S_DATA:
        if (full) nxt = S_WRITE;
      S_WRITE:
        nxt = (cnt_nxt == n) ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:
        if (take) nxt = cks_ok ? S_DONE : S_ERR;
`endif
      default:
        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo <= '0;
      n      <= '0;
      cnt    <= '0;
      addr   <= '0;
      ec     <= ERR_NONE;
    end else if (go) begin
      cnt    <= '0;
      addr   <= '0;
      ec     <= ERR_NONE;
    end else begin
      if (take && state == S_LEN_LO) len_lo <= byte_data;
      if (take && state == S_LEN_HI) begin
        n <= len_in[15:0];
        if (ovf) ec <= ERR_LEN;
      end
      if (state == S_WRITE) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt_nxt;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (take && state == S_CHK && !cks_ok) ec <= ERR_CKSUM;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // running sum covers the length bytes and every data byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sum <= '0;
    else if (go)   sum <= '0;
    else if (take) sum <= sum + byte_data;
  end
`endif

  assign imem_we    = (state == S_WRITE);
  assign imem_waddr = addr;
  assign cpu_hold   = (state != S_IDLE) & (state != S_DONE);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign err_code   = ec;

endmodule
